// File: rtl/kbd_vt52_encoder_pkg.sv
// rtl/kbd_vt52_encoder_pkg.sv - keycode constants, FSM states and translation record for the VT52 encoder
package kbd_vt52_encoder_pkg;

   localparam logic [7:0] KEY_UP    = 8'h80;
   localparam logic [7:0] KEY_DOWN  = 8'h81;
   localparam logic [7:0] KEY_RIGHT = 8'h82;
   localparam logic [7:0] KEY_LEFT  = 8'h83;
   localparam logic [7:0] KEY_PF1   = 8'h84;
   localparam logic [7:0] KEY_PF2   = 8'h85;
   localparam logic [7:0] KEY_PF3   = 8'h86;
   localparam logic [7:0] KEY_PF4   = 8'h87;
   localparam logic [7:0] ASCII_ESC = 8'h1B;
   localparam logic [7:0] ASCII_CR  = 8'h0D;
   localparam logic [7:0] ASCII_LF  = 8'h0A;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FIRST  = 2'd1,
      ST_SECOND = 2'd2
   } state_e;

   // Result of translating one raw keycode into zero, one or two output bytes.
   typedef struct packed {
      logic       valid;
      logic       two;
      logic [7:0] b0;
      logic [7:0] b1;
   } xlat_t;

endpackage

// File: rtl/kbd_vt52_encoder_if.sv
// rtl/kbd_vt52_encoder_if.sv - byte stream towards the UART transmitter
interface kbd_vt52_encoder_if;
   logic [7:0] tdata;
   logic       tvalid;
   logic       tready;

   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/kbd_vt52_encoder_sync_fifo.sv
// rtl/kbd_vt52_encoder_sync_fifo.sv - single-clock first-word-fall-through keycode FIFO
module kbd_sync_fifo #(
   parameter int DEPTH    = 16,
   parameter int LVL_BITS = 5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                wr_en_i,
   input  logic [7:0]          din_i,
   input  logic                pop_i,
   output logic [7:0]          dout_o,
   output logic                empty_o,
   output logic                full_o,
   output logic [LVL_BITS-1:0] level_o
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [7:0]          mem_q [DEPTH];
   logic [AW-1:0]       wr_ptr_q;
   logic [AW-1:0]       rd_ptr_q;
   logic [LVL_BITS-1:0] level_q;
   logic [LVL_BITS-1:0] level_d;

   always_comb begin
      level_d = level_q;
      if (wr_en_i && !pop_i) begin
         level_d = level_q + 1'b1;
      end else if (!wr_en_i && pop_i) begin
         level_d = level_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

   // DEPTH is a power of two, so pointer wrap is plain binary overflow.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (wr_en_i) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_i)   rd_ptr_q <= rd_ptr_q + 1'b1;
         level_q <= level_d;
      end
   end

   assign dout_o  = mem_q[rd_ptr_q];
   assign empty_o = (level_q == '0);
   assign full_o  = (level_q == LVL_BITS'(DEPTH));
   assign level_o = level_q;

endmodule

// File: rtl/kbd_vt52_encoder.sv
// rtl/kbd_vt52_encoder.sv - queues keyboard codes and emits VT52 byte sequences on a valid/ready stream
module kbd_vt52_encoder
   import kbd_vt52_encoder_pkg::*;
#(
   parameter int DEPTH    = 16,
   parameter int ADD_LF   = 0,
   parameter int LVL_BITS = 5
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [7:0]             kbd_data,
   input  logic                   kbd_strobe,
   kbd_vt52_encoder_if.master     m_axis,
   output logic                   overflow,
   output logic [LVL_BITS-1:0]    fifo_level
);

   function automatic xlat_t xlate(input logic [7:0] code);
      xlat_t x;
      x    = '0;
      x.b0 = ASCII_ESC;
      if (!code[7]) begin
         x.valid = 1'b1;
         x.b0    = code;
         x.two   = (ADD_LF != 0) && (code == ASCII_CR);
         x.b1    = ASCII_LF;
      end else begin
         x.valid = 1'b1;
         x.two   = 1'b1;
         case (code)
            KEY_UP:    x.b1 = 8'h41;
            KEY_DOWN:  x.b1 = 8'h42;
            KEY_RIGHT: x.b1 = 8'h43;
            KEY_LEFT:  x.b1 = 8'h44;
            KEY_PF1:   x.b1 = 8'h50;
            KEY_PF2:   x.b1 = 8'h51;
            KEY_PF3:   x.b1 = 8'h52;
            KEY_PF4:   x.b1 = 8'h53;
            default: begin
               x.valid = 1'b0;
               x.two   = 1'b0;
            end
         endcase
      end
      return x;
   endfunction

   state_e     state_q, state_d;
   logic [7:0] tdata_q, tdata_d;
   logic       tvalid_q, tvalid_d;
   logic [7:0] second_q, second_d;
   logic       two_q, two_d;
   logic       overflow_q;

   logic       pop;
   logic       wr_en;
   logic [7:0] fifo_dout;
   logic       fifo_empty;
   logic       fifo_full;
   xlat_t      xl;

   // A full FIFO still accepts a strobe when the same edge frees a slot.
   assign wr_en = kbd_strobe && (!fifo_full || pop);
   assign xl    = xlate(fifo_dout);

   kbd_sync_fifo #(
      .DEPTH    (DEPTH),
      .LVL_BITS (LVL_BITS)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en_i (wr_en),
      .din_i   (kbd_data),
      .pop_i   (pop),
      .dout_o  (fifo_dout),
      .empty_o (fifo_empty),
      .full_o  (fifo_full),
      .level_o (fifo_level)
   );

   always_comb begin
      state_d  = state_q;
      tdata_d  = tdata_q;
      tvalid_d = tvalid_q;
      second_d = second_q;
      two_d    = two_q;
      pop      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop = 1'b1;
               if (xl.valid) begin
                  tdata_d  = xl.b0;
                  second_d = xl.b1;
                  two_d    = xl.two;
                  tvalid_d = 1'b1;
                  state_d  = ST_FIRST;
               end
            end
         end
         ST_FIRST: begin
            if (m_axis.tready) begin
               if (two_q) begin
                  tdata_d = second_q;
                  state_d = ST_SECOND;
               end else begin
                  tvalid_d = 1'b0;
                  state_d  = ST_IDLE;
               end
            end
         end
         ST_SECOND: begin
            if (m_axis.tready) begin
               tvalid_d = 1'b0;
               state_d  = ST_IDLE;
            end
         end
         default: begin
            tvalid_d = 1'b0;
            state_d  = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         tdata_q    <= 8'h00;
         tvalid_q   <= 1'b0;
         second_q   <= 8'h00;
         two_q      <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         tdata_q    <= tdata_d;
         tvalid_q   <= tvalid_d;
         second_q   <= second_d;
         two_q      <= two_d;
         overflow_q <= kbd_strobe && !wr_en;
      end
   end

   assign m_axis.tdata  = tdata_q;
   assign m_axis.tvalid = tvalid_q;
   assign overflow      = overflow_q;

endmodule

// File: tb/tb_kbd_vt52_encoder.sv
// tb/tb_kbd_vt52_encoder.sv - directed and randomized checks of two encoder instances (ADD_LF=0 and ADD_LF=1)
module tb_kbd_vt52_encoder;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       kbd_strobe = 1'b0;
   logic [7:0] kbd_data = 8'h00;
   logic       tready = 1'b0;

   logic       ovf0, ovf1;
   logic [4:0] lvl0, lvl1;
   logic       tv [2];
   logic [7:0] td [2];
   logic       ovf [2];
   logic [4:0] lvl [2];

   always #5 clk = ~clk;

   kbd_vt52_encoder_if axis0 ();
   kbd_vt52_encoder_if axis1 ();
   assign axis0.tready = tready;
   assign axis1.tready = tready;

   kbd_vt52_encoder #(.DEPTH(16), .ADD_LF(0), .LVL_BITS(5)) dut0 (
      .clk        (clk),
      .reset      (reset),
      .kbd_data   (kbd_data),
      .kbd_strobe (kbd_strobe),
      .m_axis     (axis0),
      .overflow   (ovf0),
      .fifo_level (lvl0)
   );

   kbd_vt52_encoder #(.DEPTH(16), .ADD_LF(1), .LVL_BITS(5)) dut1 (
      .clk        (clk),
      .reset      (reset),
      .kbd_data   (kbd_data),
      .kbd_strobe (kbd_strobe),
      .m_axis     (axis1),
      .overflow   (ovf1),
      .fifo_level (lvl1)
   );

   assign tv[0]  = axis0.tvalid;
   assign tv[1]  = axis1.tvalid;
   assign td[0]  = axis0.tdata;
   assign td[1]  = axis1.tdata;
   assign ovf[0] = ovf0;
   assign ovf[1] = ovf1;
   assign lvl[0] = lvl0;
   assign lvl[1] = lvl1;

   // Stream monitor: records accepted bytes, overflow pulses and stall-stability violations.
   logic [7:0] got_q [2][$];
   int         ovf_cnt [2] = '{0, 0};
   int         prot_viol = 0;
   logic       prev_stall [2] = '{1'b0, 1'b0};
   logic [7:0] prev_data [2] = '{8'h00, 8'h00};
   logic       prev_reset = 1'b1;

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (prev_stall[d] && !prev_reset && (tv[d] !== 1'b1 || td[d] !== prev_data[d]))
            prot_viol++;
         if (tv[d] && tready && !reset)
            got_q[d].push_back(td[d]);
         if (ovf[d])
            ovf_cnt[d]++;
         prev_stall[d] = tv[d] && !tready;
         prev_data[d]  = td[d];
      end
      prev_reset = reset;
   end

   int         vectors = 0;
   int         miscompares = 0;
   logic [7:0] exp_q [2][$];
   int         ck [2] = '{0, 0};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_both(input string tag, input logic ev, input logic [7:0] ed);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("%s_tvalid%0d", tag, d), 32'(tv[d]), 32'(ev));
         if (ev) check($sformatf("%s_tdata%0d", tag, d), 32'(td[d]), 32'(ed));
      end
   endtask

   task automatic chk_lvl(input string tag, input int el);
      for (int d = 0; d < 2; d++)
         check($sformatf("%s_level%0d", tag, d), 32'(lvl[d]), 32'(el));
   endtask

   // Reference translation: table of what each keycode must produce on the wire.
   task automatic model_push(input logic [7:0] code);
      for (int d = 0; d < 2; d++) begin
         if (code < 8'h80) begin
            exp_q[d].push_back(code);
            if (code == 8'h0D && d == 1) exp_q[d].push_back(8'h0A);
         end else begin
            case (code)
               8'h80: begin exp_q[d].push_back(8'h1B); exp_q[d].push_back(8'h41); end
               8'h81: begin exp_q[d].push_back(8'h1B); exp_q[d].push_back(8'h42); end
               8'h82: begin exp_q[d].push_back(8'h1B); exp_q[d].push_back(8'h43); end
               8'h83: begin exp_q[d].push_back(8'h1B); exp_q[d].push_back(8'h44); end
               8'h84: begin exp_q[d].push_back(8'h1B); exp_q[d].push_back(8'h50); end
               8'h85: begin exp_q[d].push_back(8'h1B); exp_q[d].push_back(8'h51); end
               8'h86: begin exp_q[d].push_back(8'h1B); exp_q[d].push_back(8'h52); end
               8'h87: begin exp_q[d].push_back(8'h1B); exp_q[d].push_back(8'h53); end
               default: ;
            endcase
         end
      end
   endtask

   task automatic cmp_streams(input string tag);
      for (int d = 0; d < 2; d++) begin
         int n;
         check($sformatf("%s_count%0d", tag, d), 32'(got_q[d].size()), 32'(exp_q[d].size()));
         n = (got_q[d].size() < exp_q[d].size()) ? got_q[d].size() : exp_q[d].size();
         for (int i = ck[d]; i < n; i++)
            check($sformatf("%s_byte%0d_dut%0d", tag, i, d), 32'(got_q[d][i]), 32'(exp_q[d][i]));
         ck[d] = exp_q[d].size();
      end
      check({tag, "_protocol"}, 32'(prot_viol), 32'd0);
   endtask

   task automatic drain(input int budget, input bit rnd);
      int n;
      n = 0;
      while (n < budget && (tv[0] || tv[1] || lvl[0] != 0 || lvl[1] != 0)) begin
         tready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         tick();
         n++;
      end
      check("drain_done", 32'(n < budget), 32'd1);
   endtask

   initial begin
      int         ovf_base [2];
      logic [7:0] code;

      reset = 1'b1;
      tick();
      tick();
      chk_both("reset", 1'b0, 8'h00);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("reset_tdata%0d", d), 32'(td[d]), 32'h0);
         check($sformatf("reset_ovf%0d", d), 32'(ovf[d]), 32'h0);
      end
      chk_lvl("reset", 0);
      reset = 1'b0;
      tready = 1'b1;
      tick();

      // Single printable key: two-cycle latency, one beat.
      kbd_data = 8'h41; kbd_strobe = 1'b1; model_push(8'h41);
      tick();
      kbd_strobe = 1'b0;
      chk_lvl("a_lvl1", 1);
      chk_both("a_n0", 1'b0, 8'h00);
      tick();
      chk_both("a_beat", 1'b1, 8'h41);
      chk_lvl("a_lvl0", 0);
      tick();
      chk_both("a_done", 1'b0, 8'h00);
      cmp_streams("a");

      // Cursor-up: back-to-back escape pair.
      kbd_data = 8'h80; kbd_strobe = 1'b1; model_push(8'h80);
      tick();
      kbd_strobe = 1'b0;
      tick();
      chk_both("b_esc", 1'b1, 8'h1B);
      tick();
      chk_both("b_sec", 1'b1, 8'h41);
      tick();
      chk_both("b_done", 1'b0, 8'h00);
      cmp_streams("b");

      // PF2 under a ten-cycle stall.
      tready = 1'b0;
      kbd_data = 8'h85; kbd_strobe = 1'b1; model_push(8'h85);
      tick();
      kbd_strobe = 1'b0;
      tick();
      chk_both("c_esc", 1'b1, 8'h1B);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk_both($sformatf("c_stall%0d", i), 1'b1, 8'h1B);
      end
      tready = 1'b1;
      tick();
      chk_both("c_sec", 1'b1, 8'h51);
      tick();
      chk_both("c_done", 1'b0, 8'h00);
      cmp_streams("c");

      // Fill while the output is stalled holding a key, then overflow on the 17th strobe.
      for (int d = 0; d < 2; d++) ovf_base[d] = ovf_cnt[d];
      tready = 1'b0;
      kbd_data = 8'h7A; kbd_strobe = 1'b1; model_push(8'h7A);
      tick();
      kbd_strobe = 1'b0;
      tick();
      chk_both("d_hold", 1'b1, 8'h7A);
      for (int i = 0; i < 17; i++) begin
         kbd_data = 8'(8'h30 + i); kbd_strobe = 1'b1;
         if (i < 16) model_push(8'(8'h30 + i));
         tick();
         chk_lvl($sformatf("d_fill%0d", i), (i < 16) ? i + 1 : 16);
         for (int d = 0; d < 2; d++)
            check($sformatf("d_ovf%0d_dut%0d", i, d), 32'(ovf[d]), 32'(i == 16));
      end
      kbd_strobe = 1'b0;
      tick();
      for (int d = 0; d < 2; d++) begin
         check($sformatf("d_ovf_clear%0d", d), 32'(ovf[d]), 32'd0);
         check($sformatf("d_ovf_pulses%0d", d), 32'(ovf_cnt[d] - ovf_base[d]), 32'd1);
      end
      // Strobe into a full FIFO on the same edge as a pop.
      tready = 1'b1;
      tick();
      chk_lvl("d_full_idle", 16);
      chk_both("d_idle", 1'b0, 8'h00);
      kbd_data = 8'h42; kbd_strobe = 1'b1; model_push(8'h42);
      tick();
      kbd_strobe = 1'b0;
      chk_lvl("d_full_wrpop", 16);
      chk_both("d_pop30", 1'b1, 8'h30);
      for (int d = 0; d < 2; d++)
         check($sformatf("d_no_ovf%0d", d), 32'(ovf[d]), 32'd0);
      drain(200, 1'b0);
      cmp_streams("d");

      // CR, a discarded code, then a letter.
      tready = 1'b1;
      kbd_data = 8'h0D; kbd_strobe = 1'b1; model_push(8'h0D);
      tick();
      kbd_data = 8'h9A; model_push(8'h9A);
      tick();
      kbd_data = 8'h61; model_push(8'h61);
      tick();
      kbd_strobe = 1'b0;
      drain(200, 1'b0);
      cmp_streams("e");

      // Reset while stalled on the second byte of cursor-left.
      tready = 1'b0;
      kbd_data = 8'h83; kbd_strobe = 1'b1;
      for (int d = 0; d < 2; d++) exp_q[d].push_back(8'h1B);
      tick();
      kbd_strobe = 1'b0;
      tick();
      chk_both("f_esc", 1'b1, 8'h1B);
      tready = 1'b1;
      kbd_data = 8'h55; kbd_strobe = 1'b1;
      tick();
      kbd_strobe = 1'b0;
      tready = 1'b0;
      chk_both("f_sec", 1'b1, 8'h44);
      chk_lvl("f_queued", 1);
      tick();
      chk_both("f_stall", 1'b1, 8'h44);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk_both("f_reset", 1'b0, 8'h00);
      for (int d = 0; d < 2; d++)
         check($sformatf("f_reset_tdata%0d", d), 32'(td[d]), 32'h0);
      chk_lvl("f_reset", 0);
      tready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk_both($sformatf("f_quiet%0d", i), 1'b0, 8'h00);
      end
      cmp_streams("f");

      // Randomized bursts, never more than 12 keys outstanding so no overflow is possible.
      for (int d = 0; d < 2; d++) ovf_base[d] = ovf_cnt[d];
      for (int b = 0; b < 8; b++) begin
         int n;
         int sent;
         n = $urandom_range(4, 12);
         sent = 0;
         while (sent < n) begin
            tready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) != 0) begin
               case ($urandom_range(0, 3))
                  0: code = 8'($urandom_range(8'h80, 8'h8F));
                  1: code = 8'h0D;
                  default: code = 8'($urandom_range(0, 255));
               endcase
               kbd_data = code;
               kbd_strobe = 1'b1;
               model_push(code);
               sent++;
            end else begin
               kbd_strobe = 1'b0;
            end
            tick();
         end
         kbd_strobe = 1'b0;
         drain(500, 1'b1);
         cmp_streams($sformatf("rnd%0d", b));
      end
      for (int d = 0; d < 2; d++)
         check($sformatf("rnd_no_ovf%0d", d), 32'(ovf_cnt[d] - ovf_base[d]), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule
